// File: rtl/ram_master_pkg.sv
// Shared definitions for the data-RAM initiator.
//   - op_e: 3-bit load/store operator codes shared with the MEM stage.
//   - RAM strobe levels (enabled/disabled) for chip, read and write enables.
//   - state_e: initiator FSM state encodings.
//   - is_store(): true for SB/SH/SW.
package ram_master_pkg;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLbu = 3'd1,
    OpLh  = 3'd2,
    OpLhu = 3'd3,
    OpLw  = 3'd4,
    OpSb  = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } op_e;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  function automatic logic is_store(op_e op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// Single-port data RAM bus.
//   master: drives chip_enable, read_enable, read_address, write_enable,
//           write_address, write_select, write_data; samples read_data.
//   slave:  the RAM; returns combinational read_data, writes on negedge.
// write_select bit3 covers data bits [31:24] (byte offset 0, big-endian).
interface ram_master_if;
  logic        chip_enable;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        write_enable;
  logic [31:0] write_address;
  logic [3:0]  write_select;
  logic [31:0] write_data;

  modport master (
    output chip_enable, read_enable, read_address,
    output write_enable, write_address, write_select, write_data,
    input  read_data
  );

  modport slave (
    input  chip_enable, read_enable, read_address,
    input  write_enable, write_address, write_select, write_data,
    output read_data
  );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for loads and stores (purely combinational).
//   operator     : load/store operator
//   offset       : byte offset within the word (address[1:0])
//   store_data   : right-justified store data
//   read_data    : word read from the RAM
//   write_select : byte lanes to write (0 for loads)
//   write_data   : store data replicated onto every lane (0 for loads)
//   load_data    : selected, sign/zero-extended load data (0 for stores)
//   misaligned   : halfword not on even address or word not on word boundary
module mem_lane_align
  import ram_master_pkg::*;
(
  input  op_e         operator,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  write_select,
  output logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Offset 0 is the most significant byte, so shift right by 8*(3-offset).
  assign byte_val = 8'(read_data >> {~offset, 3'b000});
  assign half_val = offset[1] ? read_data[15:0] : read_data[31:16];

  always_comb begin
    write_select = 4'b0000;
    write_data   = 32'h0;
    load_data    = 32'h0;
    misaligned   = 1'b0;
    case (operator)
      OpLb:  load_data = {{24{byte_val[7]}}, byte_val};
      OpLbu: load_data = {24'h0, byte_val};
      OpLh: begin
        misaligned = offset[0];
        load_data  = {{16{half_val[15]}}, half_val};
      end
      OpLhu: begin
        misaligned = offset[0];
        load_data  = {16'h0, half_val};
      end
      OpSb: begin
        write_select = 4'b1000 >> offset;
        write_data   = {4{store_data[7:0]}};
      end
      OpSh: begin
        misaligned   = offset[0];
        write_select = offset[1] ? 4'b0011 : 4'b1100;
        write_data   = {2{store_data[15:0]}};
      end
      OpSw: begin
        misaligned   = |offset;
        write_select = 4'b1111;
        write_data   = store_data;
      end
      default: begin
        // OpLw and any unexpected code behave as a word load.
        misaligned = |offset;
        load_data  = read_data;
      end
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// Initiator for the single-port data RAM.
// Takes one load/store at a time from the MEM stage (req_* valid/ready),
// holds the RAM strobes for ACCESS_CYCLES cycles, then presents an aligned,
// extended result on resp_* until resp_ready.
//   clock, reset    : clock; asynchronous active-low reset
//   req_*           : request handshake, operator, byte address, store data
//   resp_*          : response handshake, load data, misalignment error
//   ram             : RAM bus (master side)
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned COUNT_WIDTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_operator,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  ram_master_if.master ram
);

  localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(ACCESS_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  op_e                    op_q, op_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            sdata_q, sdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  op_e         al_op;
  logic [1:0]  al_offset;
  logic [3:0]  al_select;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misaligned;

  // In IDLE the aligner judges the incoming request; afterwards the latched one.
  assign al_op     = (state_q == StIdle) ? op_e'(req_operator) : op_q;
  assign al_offset = (state_q == StIdle) ? req_address[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .operator     (al_op),
    .offset       (al_offset),
    .store_data   (sdata_q),
    .read_data    (ram.read_data),
    .write_select (al_select),
    .write_data   (al_wdata),
    .load_data    (al_load),
    .misaligned   (al_misaligned)
  );

  assign ram.read_address  = {addr_q[31:2], 2'b00};
  assign ram.write_address = {addr_q[31:2], 2'b00};
  assign resp_data         = rdata_q;
  assign resp_error        = err_q;

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    op_d             = op_q;
    addr_d           = addr_q;
    sdata_d          = sdata_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    ram.chip_enable  = CHIP_DISABLE;
    ram.read_enable  = READ_DISABLE;
    ram.write_enable = WRITE_DISABLE;
    ram.write_select = 4'b0000;
    ram.write_data   = 32'h0;

    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_operator);
          addr_d  = req_address;
          sdata_d = req_store_data;
          count_d = '0;
          rdata_d = 32'h0;
          err_d   = al_misaligned;
          state_d = al_misaligned ? StResp : StAccess;
        end
      end
      StAccess: begin
        ram.chip_enable = CHIP_ENABLE;
        if (is_store(op_q)) begin
          // The RAM writes on every negedge while enabled; repeats are idempotent.
          ram.write_enable = WRITE_ENABLE;
          ram.write_select = al_select;
          ram.write_data   = al_wdata;
        end else begin
          ram.read_enable = READ_ENABLE;
        end
        count_d = count_q + COUNT_WIDTH'(1);
        if (count_q == LastCount) begin
          if (!is_store(op_q)) rdata_d = al_load;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= OpLb;
      addr_q  <= 32'h0;
      sdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: one instance with ACCESS_CYCLES=1 and one
// with ACCESS_CYCLES=3, each with its own negedge-write RAM model.
module tb_ram_master;
  import ram_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid1, req_valid3;
  logic [2:0]  req_operator;
  logic [31:0] req_address, req_store_data;
  logic        resp_ready;
  logic        req_ready1, req_ready3, resp_valid1, resp_valid3;
  logic        resp_error1, resp_error3;
  logic [31:0] resp_data1, resp_data3;
  logic        sel;

  always #5 clock = ~clock;

  ram_master_if bus1 ();
  ram_master_if bus3 ();

  ram_master #(.ACCESS_CYCLES(1), .COUNT_WIDTH(4)) dut1 (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid1),
    .req_ready      (req_ready1),
    .req_operator   (req_operator),
    .req_address    (req_address),
    .req_store_data (req_store_data),
    .resp_valid     (resp_valid1),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data1),
    .resp_error     (resp_error1),
    .ram            (bus1)
  );

  ram_master #(.ACCESS_CYCLES(3), .COUNT_WIDTH(4)) dut3 (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid3),
    .req_ready      (req_ready3),
    .req_operator   (req_operator),
    .req_address    (req_address),
    .req_store_data (req_store_data),
    .resp_valid     (resp_valid3),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data3),
    .resp_error     (resp_error3),
    .ram            (bus3)
  );

  // RAM models: combinational read, byte-lane write on negedge.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(negedge clock)
    if (bus1.chip_enable && bus1.write_enable)
      mem1[bus1.write_address[7:2]] <= merge(mem1[bus1.write_address[7:2]],
                                             bus1.write_data, bus1.write_select);
  always @(negedge clock)
    if (bus3.chip_enable && bus3.write_enable)
      mem3[bus3.write_address[7:2]] <= merge(mem3[bus3.write_address[7:2]],
                                             bus3.write_data, bus3.write_select);

  assign bus1.read_data = mem1[bus1.read_address[7:2]];
  assign bus3.read_data = mem3[bus3.read_address[7:2]];

  int ce_cycles1 = 0;
  int ce_cycles3 = 0;
  always @(posedge clock) if (bus1.chip_enable) ce_cycles1 <= ce_cycles1 + 1;
  always @(posedge clock) if (bus3.chip_enable) ce_cycles3 <= ce_cycles3 + 1;

  // View of the instance currently under test.
  wire        cur_req_ready  = sel ? req_ready3  : req_ready1;
  wire        cur_resp_valid = sel ? resp_valid3 : resp_valid1;
  wire [31:0] cur_resp_data  = sel ? resp_data3  : resp_data1;
  wire        cur_resp_error = sel ? resp_error3 : resp_error1;
  wire        cur_ce         = sel ? bus3.chip_enable  : bus1.chip_enable;
  wire        cur_we         = sel ? bus3.write_enable : bus1.write_enable;
  wire [3:0]  cur_ws         = sel ? bus3.write_select : bus1.write_select;
  wire [31:0] cur_wd         = sel ? bus3.write_data   : bus1.write_data;
  wire [31:0] cur_waddr      = sel ? bus3.write_address : bus1.write_address;
  wire [31:0] cur_raddr      = sel ? bus3.read_address  : bus1.read_address;
  wire [31:0] cur_ce_cycles  = sel ? 32'(ce_cycles3) : 32'(ce_cycles1);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input string tag, input op_e op, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic chk_lanes, input logic [3:0] exp_ws,
                        input logic [31:0] exp_wd);
    int n;
    req_operator   = op;
    req_address    = addr;
    req_store_data = data;
    if (sel) req_valid3 = 1'b1;
    else     req_valid1 = 1'b1;
    chk({tag, " req_ready"}, 32'(cur_req_ready), 32'd1);
    step();
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    if (chk_lanes) begin
      chk({tag, " write_select"}, {28'h0, cur_ws}, {28'h0, exp_ws});
      chk({tag, " write_data"}, cur_wd, exp_wd);
    end
    n = 0;
    while (!cur_resp_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " resp_data"}, cur_resp_data, exp_data);
    chk({tag, " resp_error"}, 32'(cur_resp_error), 32'(exp_err));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, 32'(cur_resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] c0;
    int ce_hi, rr_hi, rv_hi, bad;

    reset          = 1'b0;
    sel            = 1'b0;
    req_valid1     = 1'b0;
    req_valid3     = 1'b0;
    req_operator   = 3'd0;
    req_address    = 32'h0;
    req_store_data = 32'h0;
    resp_ready     = 1'b0;
    step();
    step();

    // Reset values.
    chk("rst req_ready", 32'(cur_req_ready), 32'd1);
    chk("rst resp_valid", 32'(cur_resp_valid), 32'd0);
    chk("rst resp_data", cur_resp_data, 32'h0);
    chk("rst resp_error", 32'(cur_resp_error), 32'd0);
    chk("rst chip_enable", 32'(cur_ce), 32'd0);
    chk("rst write_select", {28'h0, cur_ws}, 32'h0);
    chk("rst write_data", cur_wd, 32'h0);
    chk("rst read_address", cur_raddr, 32'h0);
    chk("rst write_address", cur_waddr, 32'h0);
    chk("rst req_ready3", 32'(req_ready3), 32'd1);
    reset = 1'b1;
    step();

    // ACCESS_CYCLES = 1
    do_req("sw10",  OpSw,  32'h10, 32'hAABBCCDD, 1, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hAABBCCDD);
    do_req("lw10",  OpLw,  32'h10, 32'h0, 1, 32'hAABBCCDD, 1'b0, 1'b1, 4'b0000, 32'h0);
    do_req("sw20",  OpSw,  32'h20, 32'h11223344, 1, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h11223344);
    do_req("sb21",  OpSb,  32'h21, 32'h000000EE, 1, 32'h0, 1'b0, 1'b1, 4'b0100, 32'hEEEEEEEE);
    do_req("lw20",  OpLw,  32'h20, 32'h0, 1, 32'h11EE3344, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("lb21",  OpLb,  32'h21, 32'h0, 1, 32'hFFFFFFEE, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("lbu21", OpLbu, 32'h21, 32'h0, 1, 32'h000000EE, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("sw30",  OpSw,  32'h30, 32'h12345678, 1, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("sh32",  OpSh,  32'h32, 32'h00008001, 1, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h80018001);
    do_req("lh32",  OpLh,  32'h32, 32'h0, 1, 32'hFFFF8001, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("lhu32", OpLhu, 32'h32, 32'h0, 1, 32'h00008001, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("lw30",  OpLw,  32'h30, 32'h0, 1, 32'h12348001, 1'b0, 1'b0, 4'b0000, 32'h0);
    do_req("lh30",  OpLh,  32'h30, 32'h0, 1, 32'h00001234, 1'b0, 1'b0, 4'b0000, 32'h0);

    // Misaligned requests: error response, no RAM activity.
    do_req("sw04",  OpSw,  32'h04, 32'hCAFEBABE, 1, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0);
    c0 = cur_ce_cycles;
    do_req("lw13",  OpLw,  32'h13, 32'h0, 0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    do_req("sh05",  OpSh,  32'h05, 32'h0000FFFF, 0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    chk("misaligned chip_enable cycles", cur_ce_cycles - c0, 32'd0);
    do_req("lw04",  OpLw,  32'h04, 32'h0, 1, 32'hCAFEBABE, 1'b0, 1'b0, 4'b0000, 32'h0);

    // ACCESS_CYCLES = 3
    sel = 1'b1;
    do_req("ac3 sw08", OpSw, 32'h08, 32'h01020304, 3, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h01020304);
    req_operator = OpLw;
    req_address  = 32'h08;
    req_valid3   = 1'b1;
    step();
    req_valid3 = 1'b0;
    ce_hi = 0; rr_hi = 0; rv_hi = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (cur_ce) ce_hi++;
      if (cur_req_ready) rr_hi++;
      if (cur_resp_valid) begin
        rv_hi++;
        if (cur_resp_data !== 32'h01020304 || cur_resp_error !== 1'b0) bad++;
      end
      step();
    end
    chk("ac3 strobe cycles", 32'(ce_hi), 32'd3);
    chk("ac3 req_ready low", 32'(rr_hi), 32'd0);
    chk("ac3 resp_valid held", 32'(rv_hi), 32'd5);
    chk("ac3 resp_data stable", 32'(bad), 32'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("ac3 resp_valid drop", 32'(cur_resp_valid), 32'd0);
    chk("ac3 req_ready back", 32'(cur_req_ready), 32'd1);
    do_req("ac3 lb0b", OpLb, 32'h0B, 32'h0, 3, 32'h00000004, 1'b0, 1'b0, 4'b0000, 32'h0);

    // Reset during ACCESS, before the first negedge write.
    do_req("ac3 sw40", OpSw, 32'h40, 32'h55667788, 3, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0);
    req_operator   = OpSw;
    req_address    = 32'h40;
    req_store_data = 32'hDEADBEEF;
    req_valid3     = 1'b1;
    step();
    req_valid3 = 1'b0;
    chk("mid chip_enable", 32'(cur_ce), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid rst chip_enable", 32'(cur_ce), 32'd0);
    chk("mid rst write_enable", 32'(cur_we), 32'd0);
    chk("mid rst write_select", {28'h0, cur_ws}, 32'h0);
    chk("mid rst write_data", cur_wd, 32'h0);
    chk("mid rst write_address", cur_waddr, 32'h0);
    chk("mid rst req_ready", 32'(cur_req_ready), 32'd1);
    chk("mid rst resp_valid", 32'(cur_resp_valid), 32'd0);
    #5;
    reset = 1'b1;
    step();
    do_req("ac3 lw40", OpLw, 32'h40, 32'h0, 3, 32'h55667788, 1'b0, 1'b0, 4'b0000, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator side of the single-port data RAM interface (chip_enable / read_enable / read_address / read_data / write_enable / write_address / write_select / write_data).
- Accepts one load/store request at a time from the MEM stage over a valid/ready handshake and drives the RAM strobes for a configurable number of wait-state cycles.
- Performs big-endian byte/halfword lane steering and returns aligned, extended load data with a valid/ready response.

Parameters:
- ACCESS_CYCLES, 1, cycles the RAM strobes are held per access (>=1); the last cycle samples read_data.
- COUNT_WIDTH, 4, width of the wait-state counter; must satisfy ACCESS_CYCLES < 2**COUNT_WIDTH.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- req_operator  input  3  LB, LBU, LH, LHU, LW, SB, SH, SW (shared codes).
- req_address  input  32  byte address.
- req_store_data  input  32  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_data  output  32  aligned, extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned address; no RAM access made.
- chip_enable  output  1  `CHIP_ENABLE during ACCESS, else deasserted.
- read_enable  output  1  `READ_ENABLE during ACCESS of a load.
- read_address  output  32  latched address, word-aligned ([1:0]=0).
- read_data  input  32  combinational RAM read data.
- write_enable  output  1  `WRITE_ENABLE during ACCESS of a store.
- write_address  output  32  latched address, word-aligned.
- write_select  output  4  byte lanes; bit3 = bits [31:24] = byte offset 0.
- write_data  output  32  lane-replicated store data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, active-low) forces:
  - State goes to IDLE; wait-state counter and latched request are cleared.
  - All RAM strobes deasserted; write_select=0, addresses=0, write_data=0.
  - req_ready=1, resp_valid=0, resp_data=0, resp_error=0.
- Reset asserted mid-ACCESS drops write_enable immediately, so the negedge write is suppressed if reset arrives before it.
- IDLE:
  - req_valid && req_ready latches operator, address and store data.
  - Misaligned → RESP with resp_error=1. Misaligned means LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - Aligned → ACCESS with counter=0.
- ACCESS:
  - RAM strobes are decoded from the latched request; the counter increments each cycle.
  - When counter==ACCESS_CYCLES-1: for a load, read_data is captured and aligned into resp_data; then → RESP.
  - Stores rely on the RAM's negedge write; it repeats harmlessly when ACCESS_CYCLES>1.
- RESP:
  - resp_valid=1 with resp_data/resp_error held stable.
  - On resp_ready → IDLE and resp_valid drops.
  - No new request is accepted in the same cycle, so the minimum initiation interval is ACCESS_CYCLES+2.
- Latency: request accepted at edge N; resp_valid is high after edge N+ACCESS_CYCLES.
- Store lane steering (k = addr[1:0]):
  - SB: write_select = 4'b1000>>k; write_data = {4{data[7:0]}}.
  - SH: write_select = 1100 (k=0) or 0011 (k=2); write_data = {2{data[15:0]}}.
  - SW: write_select = 1111; write_data = data.
- Load extraction:
  - LB/LBU select byte read_data[31-8k -: 8] and sign/zero-extend.
  - LH/LHU select [31:16] (k=0) or [15:0] (k=2) and sign/zero-extend.
  - LW passes the word through.
- req_valid while not in IDLE is ignored (req_ready=0); the request must be held by the source.
- Undefined operator codes are treated as LW.

Decomposition:
- Shared defines header holds:
  - operator codes (3-bit);
  - `CHIP_ENABLE, `READ_ENABLE, `WRITE_ENABLE and their disabled counterparts;
  - state encodings IDLE/ACCESS/RESP.
- One combinational sub-module, mem_lane_align: operator + offset + store data → write_select/write_data; operator + offset + read_data → resp_data, misaligned flag.
- ram_master keeps the FSM, counter and registers.

Test Plan:
- SW addr 0x10 data 0xAABBCCDD, then LW 0x10 → write_select=1111; LW resp_data=0xAABBCCDD, resp_error=0, resp_valid 1 cycle after accept with ACCESS_CYCLES=1.
- SB addr 0x21 data 0x000000EE onto word 0x11223344 → write_select=0100, write_data=0xEEEEEEEE; LW 0x20 returns 0x11EE3344; LB 0x21 returns 0xFFFFFFEE; LBU 0x21 returns 0x000000EE.
- SH addr 0x32 data 0x00008001, then LH/LHU 0x32 → select=0011; LH=0xFFFF8001; LHU=0x00008001.
- LW addr 0x13, and SH addr 0x05 → resp_error=1, resp_data=0; chip_enable never asserted; no RAM contents change.
- ACCESS_CYCLES=3, resp_ready held low 4 cycles → strobes high exactly 3 cycles; resp_valid held with stable data until resp_ready; req_ready low throughout.
- Reset pulled low mid-ACCESS of SW 0x40 before negedge → strobes drop immediately, word at 0x40 unchanged, outputs at reset values, next request accepted normally.
